// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader takes the slave side; the feeding host / memory takes the master side.
interface inst_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/inst_loader.sv
// Boot-time instruction loader: parses LEN_HI, LEN_LO, 4*N little-endian data
// bytes and an XOR checksum, writes words sequentially into instruction memory
// and releases the core reset only after a complete, checksum-clean image.
module inst_loader #(
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  inst_loader_if.slave bus,
  input  logic         start,
  output logic         cpu_rst_n,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  // Memory capacity in words; a length equal to this is legal and fills memory.
  localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

  // Running frame checksum: fold one more byte into the accumulator.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic [7:0]        len_hi_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   word_cnt_r;
  logic [ADDR_W:0]   word_inc_s;
  logic [1:0]        byte_cnt_r;
  logic [23:0]       asm_r;
  logic [7:0]        xor_r;
  logic              in_ready_r;
  logic              imem_we_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [31:0]       imem_wdata_r;
  logic              done_r;
  logic              err_r;
  logic              accept_s;
  logic              word_done_s;
  logic              restart_s;
  logic              ready_nxt_s;
  logic              done_nxt_s;
  logic              err_nxt_s;
  logic [31:0]       len_ext_s;

  assign accept_s   = bus.in_valid & in_ready_r;
  assign len_ext_s  = {16'd0, len_hi_r, bus.in_data};
  assign word_inc_s = word_cnt_r + {{ADDR_W{1'b0}}, 1'b1};

  assign bus.in_ready   = in_ready_r;
  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign done           = done_r;
  assign err            = err_r;
  assign cpu_rst_n      = done_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_LEN_HI;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode from the current state and the accepted byte.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_LEN_HI: begin
        if (accept_s) state_nxt_s = S_LEN_LO;
        else          state_nxt_s = S_LEN_HI;
      end
      S_LEN_LO: begin
        if (!accept_s)              state_nxt_s = S_LEN_LO;
        else if (len_ext_s > DEPTH) state_nxt_s = S_ERR;
        else if (len_ext_s == 32'd0) state_nxt_s = S_CSUM;
        else                        state_nxt_s = S_DATA;
      end
      S_DATA: begin
        if (accept_s && (byte_cnt_r == 2'd3) && (word_inc_s == len_r)) state_nxt_s = S_CSUM;
        else                                                           state_nxt_s = S_DATA;
      end
      S_CSUM: begin
        if (!accept_s)                state_nxt_s = S_CSUM;
        else if (bus.in_data == xor_r) state_nxt_s = S_DONE;
        else                          state_nxt_s = S_ERR;
      end
      S_DONE: begin
        if (start) state_nxt_s = S_LEN_HI;
        else       state_nxt_s = S_DONE;
      end
      S_ERR: begin
        if (start) state_nxt_s = S_LEN_HI;
        else       state_nxt_s = S_ERR;
      end
      default: state_nxt_s = S_LEN_HI;
    endcase
  end

  // Per-cycle control strobes and next values of the registered status outputs.
  always_comb begin
    word_done_s = 1'b0;
    restart_s   = 1'b0;
    case (state_r)
      S_DATA: begin
        if (accept_s && (byte_cnt_r == 2'd3)) word_done_s = 1'b1;
        else                                  word_done_s = 1'b0;
      end
      S_DONE, S_ERR: begin
        restart_s = start;
      end
      default: begin
        word_done_s = 1'b0;
        restart_s   = 1'b0;
      end
    endcase
    ready_nxt_s = (state_nxt_s != S_DONE) && (state_nxt_s != S_ERR);
    done_nxt_s  = (state_nxt_s == S_DONE);
    err_nxt_s   = (state_nxt_s == S_ERR);
  end

  // Datapath: length capture, word assembly, checksum, counters and write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi_r     <= 8'd0;
      len_r        <= '0;
      word_cnt_r   <= '0;
      byte_cnt_r   <= 2'd0;
      asm_r        <= 24'd0;
      xor_r        <= 8'd0;
      in_ready_r   <= 1'b1;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= 32'd0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      in_ready_r <= ready_nxt_s;
      done_r     <= done_nxt_s;
      err_r      <= err_nxt_s;
      imem_we_r  <= word_done_s;
      if (word_done_s) begin
        imem_addr_r  <= word_cnt_r[ADDR_W-1:0];
        imem_wdata_r <= {bus.in_data, asm_r};
      end
      if (restart_s) begin
        xor_r      <= 8'd0;
        byte_cnt_r <= 2'd0;
        word_cnt_r <= '0;
      end else if (accept_s) begin
        xor_r <= csum_fold(xor_r, bus.in_data);
        case (state_r)
          S_LEN_HI: len_hi_r <= bus.in_data;
          S_LEN_LO: len_r    <= len_ext_s[ADDR_W:0];
          S_DATA: begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            // Bytes arrive LSB first, so shift in from the top of the word.
            if (byte_cnt_r == 2'd3) word_cnt_r <= word_inc_s;
            else                    asm_r      <= {bus.in_data, asm_r[23:8]};
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
